// File: rtl/alu_frame_deserializer.sv
// rtl/alu_frame_deserializer.sv - serial 11-bit packet receiver that assembles ALU command frames
// Optional CRC-4 frame check is compiled in when ALU_DESER_CRC_CHECK_EN is defined.
module alu_frame_deserializer #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sin,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] b_data,
   output logic [DATA_W-1:0] a_data,
   output logic [2:0]        op,
   output logic [3:0]        crc_rx,
   output logic              err_data,
   output logic              err_crc,
   output logic              err_op,
   output logic              overrun
);

   localparam int NBYTES = 2 * DATA_W / 8;
   localparam int CW     = $clog2(NBYTES + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(NBYTES);
   localparam logic [CW-1:0] CNT_SAT  = CW'(NBYTES + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RX   = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]          r_state;
   logic [3:0]          r_bitcnt;
   logic [8:0]          r_shift;
   logic [CW-1:0]       r_cnt;
   logic [2*DATA_W-1:0] r_frame;
   logic [2:0]          r_op;
   logic [3:0]          r_crc;
   logic                r_frm_err;
   logic                r_pend;
   logic                r_pend_drop;
   logic                r_pend_ed;
   logic                r_pend_ec;
   logic                r_pend_eo;

   logic                r_out_valid;
   logic [DATA_W-1:0]   r_b;
   logic [DATA_W-1:0]   r_a;
   logic [2:0]          r_out_op;
   logic [3:0]          r_out_crc;
   logic                r_ed;
   logic                r_ec;
   logic                r_eo;
   logic                r_over;

   logic                w_err_data;
   logic                w_crc_bad;
   logic                w_err_crc;
   logic                w_err_op;

`ifdef ALU_DESER_CRC_CHECK_EN
   function automatic logic [3:0] f_crc4(input logic [2*DATA_W+3:0] i_bits);
      logic [3:0] c;
      logic       fb;
      c = 4'b0000;
      for (int i = 2*DATA_W+3; i >= 0; i--) begin
         fb = c[3] ^ i_bits[i];
         c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
      end
      return c;
   endfunction

   assign w_crc_bad = (f_crc4({r_frame, 1'b1, r_op}) != r_crc);
`else
   assign w_crc_bad = 1'b0;
`endif

   // Error priority: framing/count beats CRC, CRC beats opcode.
   assign w_err_data = r_frm_err || (r_cnt != CNT_FULL);
   assign w_err_crc  = !w_err_data && w_crc_bad;
   assign w_err_op   = !w_err_data && !w_err_crc && r_op[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_bitcnt    <= '0;
         r_shift     <= '0;
         r_cnt       <= '0;
         r_frame     <= '0;
         r_op        <= '0;
         r_crc       <= '0;
         r_frm_err   <= 1'b0;
         r_pend      <= 1'b0;
         r_pend_drop <= 1'b0;
         r_pend_ed   <= 1'b0;
         r_pend_ec   <= 1'b0;
         r_pend_eo   <= 1'b0;
      end else begin
         r_shift <= {r_shift[7:0], sin};
         r_pend  <= 1'b0;
         // Bytes are zeroed once handed to the buffer so a short frame reads 0x00.
         if (r_pend) r_frame <= '0;
         case (r_state)
            S_IDLE: begin
               if (!sin) begin
                  r_state  <= S_RX;
                  r_bitcnt <= 4'd1;
               end
            end
            S_RX: begin
               if (r_bitcnt == 4'd10) begin
                  if (!sin) r_frm_err <= 1'b1;
                  if (r_shift[8]) begin
                     r_op    <= r_shift[6:4];
                     r_crc   <= r_shift[3:0];
                     r_state <= S_DONE;
                  end else begin
                     if (r_cnt < CNT_FULL)
                        r_frame[(2*DATA_W-1) - 8*int'(r_cnt) -: 8] <= r_shift[7:0];
                     if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_bitcnt <= r_bitcnt + 4'd1;
               end
            end
            S_DONE: begin
               r_pend      <= 1'b1;
               r_pend_drop <= r_out_valid && !out_ready;
               r_pend_ed   <= w_err_data;
               r_pend_ec   <= w_err_crc;
               r_pend_eo   <= w_err_op;
               r_cnt       <= '0;
               r_frm_err   <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_b         <= '0;
         r_a         <= '0;
         r_out_op    <= '0;
         r_out_crc   <= '0;
         r_ed        <= 1'b0;
         r_ec        <= 1'b0;
         r_eo        <= 1'b0;
         r_over      <= 1'b0;
      end else begin
         r_over <= 1'b0;
         if (r_pend && r_pend_drop) begin
            r_over <= 1'b1;
            if (r_out_valid && out_ready) r_out_valid <= 1'b0;
         end else if (r_pend) begin
            r_out_valid <= 1'b1;
            r_b         <= r_frame[2*DATA_W-1:DATA_W];
            r_a         <= r_frame[DATA_W-1:0];
            r_out_op    <= r_op;
            r_out_crc   <= r_crc;
            r_ed        <= r_pend_ed;
            r_ec        <= r_pend_ec;
            r_eo        <= r_pend_eo;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign b_data    = r_b;
   assign a_data    = r_a;
   assign op        = r_out_op;
   assign crc_rx    = r_out_crc;
   assign err_data  = r_ed;
   assign err_crc   = r_ec;
   assign err_op    = r_eo;
   assign overrun   = r_over;

endmodule

// File: tb/tb_alu_frame_deserializer.sv
// tb/tb_alu_frame_deserializer.sv - randomized frame stimulus checked against a transaction-level model
module tb_alu_frame_deserializer;

   localparam int DW = 32;
   localparam int NB = 2 * DW / 8;
`ifdef ALU_DESER_CRC_CHECK_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sin = 1'b1;
   logic          out_ready = 1'b1;
   logic          out_valid;
   logic [DW-1:0] b_data, a_data;
   logic [2:0]    op;
   logic [3:0]    crc_rx;
   logic          err_data, err_crc, err_op, overrun;

   alu_frame_deserializer #(.DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .sin(sin), .out_ready(out_ready),
      .out_valid(out_valid), .b_data(b_data), .a_data(a_data), .op(op),
      .crc_rx(crc_rx), .err_data(err_data), .err_crc(err_crc), .err_op(err_op),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // CRC as the remainder of M(x)*x^4 divided by x^4+x+1.
   function automatic logic [3:0] crc_ref(input logic [2*DW+3:0] m);
      logic [2*DW+7:0] r;
      r = {m, 4'b0000};
      for (int i = 2*DW+7; i >= 4; i--)
         if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
      return r[3:0];
   endfunction

   typedef struct {
      int            due;
      logic [DW-1:0] b;
      logic [DW-1:0] a;
      logic [2:0]    op;
      logic [3:0]    crc;
      logic          ed;
      logic          ec;
      logic          eo;
   } exp_t;

   exp_t pq[$];
   exp_t m;
   logic m_valid = 1'b0;
   logic p_drop  = 1'b0;
   int   ready_mode = 0;
   int   over_seen  = 0;
   logic [7:0] fr_bytes [0:15];

   initial begin
      logic acc, exp_over;
      int   k;
      forever begin
         @(negedge clk);
         #2;
         k = cyc;
         exp_over = 1'b0;
         if (rst) begin
            m_valid = 1'b0;
            pq.delete();
         end else begin
            acc = m_valid && out_ready;
            if (pq.size() > 0 && k == pq[0].due - 1) p_drop = m_valid && !out_ready;
            if (pq.size() > 0 && k == pq[0].due) begin
               if (p_drop) begin
                  exp_over = 1'b1;
                  if (acc) m_valid = 1'b0;
               end else begin
                  m = pq[0];
                  m_valid = 1'b1;
               end
               void'(pq.pop_front());
            end else if (acc) begin
               m_valid = 1'b0;
            end
         end
         if (overrun === 1'b1) over_seen++;
         chk("out_valid", out_valid, m_valid);
         chk("overrun", overrun, exp_over);
         if (m_valid) begin
            chk("b_data", b_data, m.b);
            chk("a_data", a_data, m.a);
            chk("op", op, m.op);
            chk("crc_rx", crc_rx, m.crc);
            chk("err_data", err_data, m.ed);
            chk("err_crc", err_crc, m.ec);
            chk("err_op", err_op, m.eo);
         end
         case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_b"}, b_data, 0);
      chk({tag, "_a"}, a_data, 0);
      chk({tag, "_op"}, op, 0);
      chk({tag, "_crc"}, crc_rx, 0);
      chk({tag, "_errs"}, {err_data, err_crc, err_op}, 0);
      chk({tag, "_over"}, overrun, 0);
   endtask

   task automatic set_ab(input logic [DW-1:0] b, input logic [DW-1:0] a);
      logic [2*DW-1:0] v;
      v = {b, a};
      for (int i = 0; i < NB; i++) fr_bytes[i] = v[2*DW-1-8*i -: 8];
   endtask

   function automatic logic [2*DW-1:0] full_val();
      logic [2*DW-1:0] v;
      for (int i = 0; i < NB; i++) v[2*DW-1-8*i -: 8] = fr_bytes[i];
      return v;
   endfunction

   function automatic logic [3:0] good_crc(input logic [2:0] o);
      return crc_ref({full_val(), 1'b1, o});
   endfunction

   task automatic send_frame(input int nd, input logic [15:0] badstop, input logic [2:0] o,
                             input logic [3:0] c, input int idle0, input int abort_at);
      logic q[$];
      logic [7:0] pl;
      logic [2*DW-1:0] v;
      exp_t e;
      for (int i = 0; i < idle0; i++) q.push_back(1'b1);
      for (int p = 0; p <= nd; p++) begin
         if (p > 0) for (int g = 0; g < int'($urandom_range(0, 2)); g++) q.push_back(1'b1);
         pl = (p == nd) ? {1'b0, o, c} : fr_bytes[p];
         q.push_back(1'b0);
         q.push_back(p == nd);
         for (int i = 7; i >= 0; i--) q.push_back(pl[i]);
         q.push_back(!badstop[p]);
      end
      v = '0;
      for (int i = 0; i < NB; i++) if (i < nd) v[2*DW-1-8*i -: 8] = fr_bytes[i];
      e.b   = v[2*DW-1:DW];
      e.a   = v[DW-1:0];
      e.op  = o;
      e.crc = c;
      e.ed  = (badstop != 0) || (nd != NB);
      e.ec  = CRC_EN && !e.ed && (crc_ref({v, 1'b1, o}) != c);
      e.eo  = !e.ed && !e.ec && !(o inside {3'b000, 3'b001, 3'b100, 3'b101});
      for (int i = 0; i < q.size(); i++) begin
         if (i == abort_at) begin
            @(negedge clk);
            rst = 1'b1;
            sin = 1'b1;
            #1;
            chk_all_zero("midrst");
            return;
         end
         @(negedge clk);
         sin = q[i];
      end
      e.due = cyc + 3;
      pq.push_back(e);
      p_drop = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sin = 1'b1;
      end
   endtask

   initial begin
      chk("crc_pin_x4", crc_ref(68'h1), 4'h3);
      chk("crc_pin_x5", crc_ref(68'h2), 4'h6);
      chk("crc_pin_x8", crc_ref(68'h10), 4'h5);

      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      idle(4);

      set_ab(32'h12345678, 32'h9ABCDEF0);
      send_frame(NB, 0, 3'b000, good_crc(3'b000), 1, -1);
      set_ab(32'h11223344, 32'h55667788);
      send_frame(NB - 1, 0, 3'b100, good_crc(3'b100), 2, -1);
      set_ab(32'hFFFFFFFF, 32'hFFFFFFFF);
      send_frame(NB, 0, 3'b101, good_crc(3'b101) + 4'd1, 1, -1);
      set_ab(32'hCAFEF00D, 32'h0BADBEEF);
      send_frame(NB, 0, 3'b110, good_crc(3'b110), 1, -1);
      send_frame(NB, 0, 3'b110, good_crc(3'b110) ^ 4'h1, 3, -1);
      send_frame(NB, 16'h0008, 3'b001, good_crc(3'b001), 1, -1);
      send_frame(NB, 16'h0100, 3'b001, good_crc(3'b001), 1, -1);
      for (int i = 8; i < 16; i++) fr_bytes[i] = 8'($urandom);
      send_frame(NB + 2, 0, 3'b100, good_crc(3'b100), 1, -1);
      send_frame(0, 0, 3'b000, good_crc(3'b000), 1, -1);
      idle(5);

      ready_mode = 1;
      idle(2);
      over_seen = 0;
      set_ab(32'hA5A5A5A5, 32'h3C3C3C3C);
      send_frame(NB, 0, 3'b000, good_crc(3'b000), 1, -1);
      set_ab(32'h01020304, 32'h05060708);
      send_frame(NB, 0, 3'b001, good_crc(3'b001), 1, -1);
      idle(6);
      chk("overrun_count", over_seen, 1);
      chk("held_b", b_data, 32'hA5A5A5A5);
      ready_mode = 0;
      idle(4);
      chk("drained", out_valid, 0);

      ready_mode = 1;
      set_ab(32'h0F0F0F0F, 32'hF0F0F0F0);
      send_frame(NB, 0, 3'b100, good_crc(3'b100), 1, -1);
      idle(4);
      send_frame(NB, 0, 3'b101, good_crc(3'b101), 1, 40);
      idle(3);
      rst = 1'b0;
      ready_mode = 0;
      idle(3);
      set_ab(32'hDEADBEEF, 32'h00C0FFEE);
      send_frame(NB, 0, 3'b101, good_crc(3'b101), 1, -1);
      idle(5);

      ready_mode = 2;
      for (int f = 0; f < 24; f++) begin
         int nd;
         logic [2:0] o;
         logic [3:0] c;
         logic [15:0] bs;
         for (int i = 0; i < 16; i++) fr_bytes[i] = 8'($urandom);
         nd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(NB - 2, NB + 2)) : NB;
         o  = 3'($urandom);
         c  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : good_crc(o);
         bs = ($urandom_range(0, 7) == 0) ? (16'h1 << $urandom_range(0, nd)) : 16'h0;
         send_frame(nd, bs, o, c, int'($urandom_range(1, 6)), -1);
      end
      ready_mode = 0;
      idle(10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
